move_entry: RTL and testbench

Cursor-driven move builder that drives the move-validation logic. It turns debounced push-button pulses into a 14-bit move word (source square, target square, side to move) and presents it to the validator. It waits a fixed settling window, samples the validator's verdict, then either commits the move and passes the turn or rejects it and restarts source selection. It sits between the button debouncers and the validator/board-update path.

---
 rtl/move_entry.sv | 79 +++++++
 tb/tb_move_entry.sv | 114 +++++++++++
 2 files changed

// File: rtl/move_entry.sv
// move_entry: cursor-driven move builder feeding the validator, with a fixed settling window before sampling its verdict.
module move_entry #(
  parameter int CHECK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        btnL,
  input  logic        btnR,
  input  logic        btnC,
  input  logic        allowMove,
  output logic [13:0] moveData,
  output logic        moveValid,
  output logic        moveReject,
  output logic [5:0]  cursor,
  output logic [1:0]  state,
  output logic        turn
);
  typedef enum logic [1:0] {SEL_SRC = 2'b00, SEL_DST = 2'b01, CHECK = 2'b10} state_t;
  localparam int CW = CHECK_CYCLES > 1 ? $clog2(CHECK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHECK_CYCLES - 1);
  state_t st;
  logic [CW-1:0] cnt;
  logic [5:0] src, moved;
  logic [2:0] col, row;
  assign state = st;
  assign col = cursor[5:3];
  assign row = cursor[2:0];
  // U > D > L > R; btnC outranks all of these and is handled in the FSM
  always_comb
    moved = btnU ? {col, row == 3'd0 ? row : row - 3'd1} :
            btnD ? {col, row == 3'd7 ? row : row + 3'd1} :
            btnL ? {col == 3'd0 ? col : col - 3'd1, row} :
            btnR ? {col == 3'd7 ? col : col + 3'd1, row} : cursor;
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= SEL_SRC;
      cursor <= 6'd39;
      src <= '0;
      cnt <= '0;
      moveData <= '0;
      moveValid <= 1'b0;
      moveReject <= 1'b0;
      turn <= 1'b0;
    end else begin
      moveValid <= 1'b0;
      moveReject <= 1'b0;
      case (st)
        SEL_SRC, SEL_DST: begin
          if (btnC) begin
            if (st == SEL_SRC) begin
              src <= cursor;
              st <= SEL_DST;
            end else if (cursor == src) begin
              st <= SEL_SRC;
            end else begin
              moveData <= {turn, 1'b0, src, cursor};
              cnt <= '0;
              st <= CHECK;
            end
          end else begin
            cursor <= moved;
          end
        end
        default: begin
          if (cnt == LAST) begin
            moveValid <= allowMove;
            moveReject <= !allowMove;
            turn <= turn ^ allowMove;
            st <= SEL_SRC;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_move_entry.sv
// tb_move_entry: directed and random stimulus against a behavioural board/turn model.
module tb_move_entry;
  localparam int CC = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic btnU = 0, btnD = 0, btnL = 0, btnR = 0, btnC = 0, allowMove = 0;
  logic [13:0] moveData;
  logic moveValid, moveReject, turn;
  logic [5:0] cursor;
  logic [1:0] state;
  int n_vec = 0, n_err = 0;
  int m_col, m_row, m_st, m_src, m_md, m_turn, m_wait;
  bit m_v, m_r;
  always #5 clk = ~clk;
  move_entry #(.CHECK_CYCLES(CC)) dut (
    .clk(clk), .reset(reset), .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
    .btnC(btnC), .allowMove(allowMove), .moveData(moveData), .moveValid(moveValid),
    .moveReject(moveReject), .cursor(cursor), .state(state), .turn(turn)
  );
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model();
    int idx;
    idx = m_col * 8 + m_row;
    m_v = 0;
    m_r = 0;
    if (reset) begin
      m_col = 4; m_row = 7; m_st = 0; m_src = 0; m_md = 0; m_turn = 0; m_wait = 0;
    end else if (m_st == 2) begin
      m_wait--;
      if (m_wait == 0) begin
        if (allowMove) begin m_v = 1; m_turn ^= 1; end
        else m_r = 1;
        m_st = 0;
      end
    end else if (btnC) begin
      if (m_st == 0) begin m_src = idx; m_st = 1; end
      else if (idx == m_src) m_st = 0;
      else begin m_md = m_turn * 8192 + m_src * 64 + idx; m_wait = CC; m_st = 2; end
    end else if (btnU) m_row = m_row > 0 ? m_row - 1 : 0;
    else if (btnD) m_row = m_row < 7 ? m_row + 1 : 7;
    else if (btnL) m_col = m_col > 0 ? m_col - 1 : 0;
    else if (btnR) m_col = m_col < 7 ? m_col + 1 : 7;
  endtask
  task automatic step(input bit u, d, l, r, c, a, rs);
    btnU = u; btnD = d; btnL = l; btnR = r; btnC = c; allowMove = a; reset = rs;
    @(posedge clk);
    model();
    #1;
    chk("cursor", cursor, m_col * 8 + m_row);
    chk("state", state, m_st);
    chk("moveData", moveData, m_md);
    chk("moveValid", moveValid, m_v);
    chk("moveReject", moveReject, m_r);
    chk("turn", turn, m_turn);
  endtask
  task automatic idle(input int n, input bit a);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, a, 0);
  endtask
  task automatic build_move(input bit a);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, a, 0);
    chk("lit_moveData", moveData, 14'h09A4);
  endtask
  initial begin
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("lit_reset_cursor", cursor, 39);
    chk("lit_reset_state", state, 0);
    idle(20, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 0, 0);
    chk("lit_clamp_right", cursor, 63);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0, 0);
    chk("lit_clamp_up", cursor, 56);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    chk("lit_u_over_l", cursor, 56);
    build_move(1);
    step(0, 0, 0, 1, 0, 1, 0);
    chk("lit_hold_cursor", cursor, 36);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("lit_valid", moveValid, 1);
    chk("lit_turn_black", turn, 1);
    chk("lit_side_kept", moveData, 14'h09A4);
    idle(3, 0);
    build_move(0);
    idle(1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("lit_reject", moveReject, 1);
    chk("lit_turn_white", turn, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("lit_cancel_state", state, 0);
    build_move(1);
    step(0, 0, 0, 0, 0, 1, 1);
    chk("lit_midcheck_md", moveData, 0);
    idle(5, 1);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 299) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
